core_bus_arbiter: RTL and testbench



---
 rtl/core_bus_arbiter_pkg.sv | 23 ++
 rtl/core_bus_arbiter_arb2_pick.sv | 33 +++
 rtl/core_bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_core_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_arbiter_pkg.sv
// core_bus_arbiter_pkg
// Shared types and constants for the core bus arbiter slice.
//   state_e : arbiter FSM states (IDLE, BUSY)
//   owner_e : which core interface owns the Wishbone transaction
//   SEL_ALL : all-ones byte select for a full-width bus word
package core_bus_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Encoding matches the bit positions of the picker's request/grant vectors.
  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam int unsigned BUS_DATA_WIDTH = 32;
  localparam int unsigned BUS_SEL_WIDTH  = BUS_DATA_WIDTH / 8;
  localparam logic [BUS_SEL_WIDTH-1:0] SEL_ALL = {BUS_SEL_WIDTH{1'b1}};

endpackage

// File: rtl/core_bus_arbiter_arb2_pick.sv
// arb2_pick
// Combinational two-way picker producing a one-hot grant.
//   req_i        : request vector, bit 0 = port 0, bit 1 = port 1
//   last_i       : index of the port served most recently
//   fixed_prio_i : 1 = port 1 wins every tie, 0 = round-robin on ties
//   gnt_o        : one-hot grant (all zero when nothing requests)
module arb2_pick
  import core_bus_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       fixed_prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      // On a round-robin tie the port that was not served last goes next.
      2'b11: begin
        if (fixed_prio_i) begin
          gnt_o = 2'b10;
        end else begin
          gnt_o = last_i ? 2'b01 : 2'b10;
        end
      end
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter
// Shares one Wishbone master port between the core's instruction and data
// req/gnt/rvalid interfaces, one transaction at a time.
//   clk, rst           : clock, asynchronous active-high reset
//   instr_*            : instruction fetch interface (read only)
//   data_*             : data interface (read/write, byte enables, error)
//   wb_*               : Wishbone master towards the Controller core_* port
// Optional build macro: CORE_BUS_ARBITER_TIMEOUT_EN adds a Wishbone wait
// limit of TIMEOUT_CYCLES; a timed-out transaction returns rdata 0 and, for
// the data port, data_err_o = 1.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = BUS_DATA_WIDTH,
  parameter int unsigned DATA_PRIORITY  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;
  localparam logic [BE_W-1:0] INSTR_SEL =
    (BE_W == BUS_SEL_WIDTH) ? BE_W'(SEL_ALL) : {BE_W{1'b1}};

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                lastOwner_q, lastOwner_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [BE_W-1:0]       sel_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] instrRdata_q, dataRdata_q;
  logic                  instrRvalid_q, dataRvalid_q;
  logic [1:0]            pickReq, pickGnt;
  logic                  launch, finish, timedOut;

  // Requests are only considered while idle and out of reset, so every gnt
  // is combinational on the same cycle as its req and never issued in BUSY.
  assign pickReq = (state_q == IDLE && !rst) ? {data_req_i, instr_req_i} : 2'b00;

  arb2_pick u_pick (
    .req_i        (pickReq),
    .last_i       (lastOwner_q == OWNER_DATA),
    .fixed_prio_i (DATA_PRIORITY != 0),
    .gnt_o        (pickGnt)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastOwner_d = lastOwner_q;
    launch      = 1'b0;
    finish      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pickGnt) begin
          launch  = 1'b1;
          state_d = BUSY;
          owner_d = pickGnt[1] ? OWNER_DATA : OWNER_INSTR;
        end
      end
      BUSY: begin
        if (wb_ack_i || timedOut) begin
          finish      = 1'b1;
          state_d     = IDLE;
          lastOwner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= OWNER_INSTR;
      lastOwner_q   <= OWNER_DATA;
      addr_q        <= '0;
      we_q          <= 1'b0;
      sel_q         <= '0;
      wdata_q       <= '0;
      instrRdata_q  <= '0;
      dataRdata_q   <= '0;
      instrRvalid_q <= 1'b0;
      dataRvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      lastOwner_q   <= lastOwner_d;
      instrRvalid_q <= finish && (owner_q == OWNER_INSTR);
      dataRvalid_q  <= finish && (owner_q == OWNER_DATA);
      if (launch) begin
        if (pickGnt[1]) begin
          addr_q  <= data_addr_i;
          we_q    <= data_we_i;
          sel_q   <= data_be_i;
          wdata_q <= data_wdata_i;
        end else begin
          addr_q  <= instr_addr_i;
          we_q    <= 1'b0;
          sel_q   <= INSTR_SEL;
          wdata_q <= '0;
        end
      end
      // A timeout without ack returns zero data.
      if (finish && owner_q == OWNER_INSTR) begin
        instrRdata_q <= wb_ack_i ? wb_data_i : '0;
      end
      if (finish && owner_q == OWNER_DATA) begin
        dataRdata_q <= wb_ack_i ? wb_data_i : '0;
      end
    end
  end

`ifdef CORE_BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic            dataErr_q;

  // The limit is hit on the last permitted BUSY cycle; an ack on that same
  // cycle still completes normally.
  assign timedOut = (state_q == BUSY) && !wb_ack_i &&
                    (toCnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    toCnt_d = toCnt_q;
    if (launch) begin
      toCnt_d = '0;
    end else if (state_q == BUSY && !wb_ack_i) begin
      toCnt_d = toCnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toCnt_q   <= '0;
      dataErr_q <= 1'b0;
    end else begin
      toCnt_q   <= toCnt_d;
      dataErr_q <= timedOut && (owner_q == OWNER_DATA);
    end
  end

  assign data_err_o = dataErr_q;
`else
  logic unusedTimeout;

  assign timedOut      = 1'b0;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
  assign data_err_o    = 1'b0;
`endif

  assign instr_gnt_o    = pickGnt[0];
  assign data_gnt_o     = pickGnt[1];
  assign instr_rvalid_o = instrRvalid_q;
  assign instr_rdata_o  = instrRdata_q;
  assign data_rvalid_o  = dataRvalid_q;
  assign data_rdata_o   = dataRdata_q;
  assign wb_cyc_o       = (state_q == BUSY);
  assign wb_stb_o       = (state_q == BUSY);
  assign wb_we_o        = we_q;
  assign wb_sel_o       = sel_q;
  assign wb_addr_o      = addr_q;
  assign wb_data_o      = wdata_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter
// Directed bench for core_bus_arbiter. Two instances share all inputs:
// fDut uses fixed data priority, rDut uses round-robin. Both accept a
// transaction whenever any request is present, so they stay in lock step.
// With CORE_BUS_ARBITER_TIMEOUT_EN both use TIMEOUT_CYCLES = 8 and the
// timeout sequence is added.
module tb_core_bus_arbiter;

`ifdef CORE_BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = 8;
`else
  localparam int unsigned TO_CYCLES = 255;
`endif

  logic        clk;
  logic        rst;
  logic        instrReq;
  logic [31:0] instrAddr;
  logic        dataReq;
  logic        dataWe;
  logic [3:0]  dataBe;
  logic [31:0] dataAddr;
  logic [31:0] dataWdata;
  logic [31:0] wbDataIn;
  logic        wbAck;

  logic        fInstrGnt, fInstrRvalid, fDataGnt, fDataRvalid, fDataErr;
  logic [31:0] fInstrRdata, fDataRdata, fWbAddr, fWbData;
  logic        fWbCyc, fWbStb, fWbWe;
  logic [3:0]  fWbSel;

  logic        rInstrGnt, rInstrRvalid, rDataGnt, rDataRvalid, rDataErr;
  logic [31:0] rInstrRdata, rDataRdata, rWbAddr, rWbData;
  logic        rWbCyc, rWbStb, rWbWe;
  logic [3:0]  rWbSel;

  int checkCount = 0;
  int failCount  = 0;

  core_bus_arbiter #(
    .DATA_PRIORITY  (1),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) fDut (
    .clk (clk), .rst (rst),
    .instr_req_i (instrReq), .instr_addr_i (instrAddr),
    .instr_gnt_o (fInstrGnt), .instr_rvalid_o (fInstrRvalid),
    .instr_rdata_o (fInstrRdata),
    .data_req_i (dataReq), .data_we_i (dataWe), .data_be_i (dataBe),
    .data_addr_i (dataAddr), .data_wdata_i (dataWdata),
    .data_gnt_o (fDataGnt), .data_rvalid_o (fDataRvalid),
    .data_rdata_o (fDataRdata), .data_err_o (fDataErr),
    .wb_cyc_o (fWbCyc), .wb_stb_o (fWbStb), .wb_we_o (fWbWe),
    .wb_sel_o (fWbSel), .wb_addr_o (fWbAddr), .wb_data_o (fWbData),
    .wb_data_i (wbDataIn), .wb_ack_i (wbAck)
  );

  core_bus_arbiter #(
    .DATA_PRIORITY  (0),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) rDut (
    .clk (clk), .rst (rst),
    .instr_req_i (instrReq), .instr_addr_i (instrAddr),
    .instr_gnt_o (rInstrGnt), .instr_rvalid_o (rInstrRvalid),
    .instr_rdata_o (rInstrRdata),
    .data_req_i (dataReq), .data_we_i (dataWe), .data_be_i (dataBe),
    .data_addr_i (dataAddr), .data_wdata_i (dataWdata),
    .data_gnt_o (rDataGnt), .data_rvalid_o (rDataRvalid),
    .data_rdata_o (rDataRdata), .data_err_o (rDataErr),
    .wb_cyc_o (rWbCyc), .wb_stb_o (rWbStb), .wb_we_o (rWbWe),
    .wb_sel_o (rWbSel), .wb_addr_o (rWbAddr), .wb_data_o (rWbData),
    .wb_data_i (wbDataIn), .wb_ack_i (wbAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs just after the rising edge, then leaves a
  // short settle time so checks land well away from either clock edge.
  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic dWe,
                               input logic [3:0] dBe, input logic [31:0] dAddr,
                               input logic [31:0] dWdata, input logic ack,
                               input logic [31:0] wbData);
    @(posedge clk);
    #1;
    instrReq  = iReq;
    instrAddr = iAddr;
    dataReq   = dReq;
    dataWe    = dWe;
    dataBe    = dBe;
    dataAddr  = dAddr;
    dataWdata = dWdata;
    wbAck     = ack;
    wbDataIn  = wbData;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst       = 1'b1;
    instrReq  = 1'b0;
    instrAddr = '0;
    dataReq   = 1'b0;
    dataWe    = 1'b0;
    dataBe    = '0;
    dataAddr  = '0;
    dataWdata = '0;
    wbAck     = 1'b0;
    wbDataIn  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_cyc", {63'd0, fWbCyc}, 64'd0);
    checkOutput("reset_stb", {63'd0, fWbStb}, 64'd0);
    checkOutput("reset_rvalid", {62'd0, fInstrRvalid, fDataRvalid}, 64'd0);
    checkOutput("reset_gnt", {62'd0, fInstrGnt, fDataGnt}, 64'd0);
    checkOutput("reset_wb_addr", {32'd0, fWbAddr}, 64'd0);
    checkOutput("reset_rdata", {fInstrRdata, fDataRdata}, 64'd0);
    rst = 1'b0;

    // Instruction-only read, ack two BUSY cycles after grant
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("i_gnt", {63'd0, fInstrGnt}, 64'd1);
    checkOutput("i_cyc_idle", {63'd0, fWbCyc}, 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("i_cyc", {62'd0, fWbCyc, fWbStb}, 64'd3);
    checkOutput("i_wb_addr", {32'd0, fWbAddr}, 64'h100);
    checkOutput("i_wb_we", {63'd0, fWbWe}, 64'd0);
    checkOutput("i_wb_sel", {60'd0, fWbSel}, 64'hF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF);
    checkOutput("i_cyc_at_ack", {63'd0, fWbCyc}, 64'd1);
    checkOutput("i_rvalid_early", {63'd0, fInstrRvalid}, 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("i_cyc_after_ack", {63'd0, fWbCyc}, 64'd0);
    checkOutput("i_rvalid", {63'd0, fInstrRvalid}, 64'd1);
    checkOutput("i_rdata", {32'd0, fInstrRdata}, 64'hDEADBEEF);
    checkOutput("i_no_data_rvalid", {63'd0, fDataRvalid}, 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("i_rvalid_pulse", {63'd0, fInstrRvalid}, 64'd0);
    checkOutput("i_rdata_hold", {32'd0, fInstrRdata}, 64'hDEADBEEF);

    // Data write
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h2004, 32'h1234, 1'b0, 32'h0);
    checkOutput("w_gnt", {62'd0, fDataGnt, fInstrGnt}, 64'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("w_wb_we", {63'd0, fWbWe}, 64'd1);
    checkOutput("w_wb_sel", {60'd0, fWbSel}, 64'h3);
    checkOutput("w_wb_data", {32'd0, fWbData}, 64'h1234);
    checkOutput("w_wb_addr", {32'd0, fWbAddr}, 64'h2004);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hCAFE0000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("w_rvalid", {62'd0, fDataRvalid, fInstrRvalid}, 64'd2);
    checkOutput("w_err", {63'd0, fDataErr}, 64'd0);

    // Tie, both held for four transactions with single-cycle acks.
    // Round-robin last owner is DATA here, so it starts with INSTR.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1'b0, 32'h0);
      checkOutput($sformatf("fix_gnt%0d", i), {62'd0, fDataGnt, fInstrGnt}, 64'd2);
      checkOutput($sformatf("rr_gnt%0d", i), {62'd0, rDataGnt, rInstrGnt},
                  (i % 2 == 0) ? 64'd1 : 64'd2);
      if (i > 0) begin
        checkOutput($sformatf("fix_rvalid%0d", i), {62'd0, fDataRvalid, fInstrRvalid}, 64'd2);
        checkOutput($sformatf("fix_rdata%0d", i), {32'd0, fDataRdata}, 64'h1000 + 64'(i - 1));
        checkOutput($sformatf("rr_rvalid%0d", i), {62'd0, rDataRvalid, rInstrRvalid},
                    ((i - 1) % 2 == 0) ? 64'd1 : 64'd2);
      end
      applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1'b1,
                    32'h1000 + 32'(i));
      checkOutput($sformatf("busy_gnt%0d", i),
                  {60'd0, fDataGnt, fInstrGnt, rDataGnt, rInstrGnt}, 64'd0);
      checkOutput($sformatf("busy_cyc%0d", i), {62'd0, fWbCyc, rWbCyc}, 64'd3);
      checkOutput($sformatf("rr_addr%0d", i), {32'd0, rWbAddr},
                  (i % 2 == 0) ? 64'h500 : 64'h600);
    end
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("fix_instr_after_drop", {62'd0, fDataGnt, fInstrGnt}, 64'd1);
    checkOutput("fix_last_rdata", {32'd0, fDataRdata}, 64'h1003);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h2000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("fix_instr_rvalid", {63'd0, fInstrRvalid}, 64'd1);
    checkOutput("fix_instr_rdata", {32'd0, fInstrRdata}, 64'h2000);

    // Reset in BUSY before ack, then a stray ack after release
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("rst_busy_cyc", {63'd0, fWbCyc}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_cyc", {62'd0, fWbCyc, fWbStb}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h55AA55AA);
    checkOutput("late_ack_cyc", {63'd0, fWbCyc}, 64'd0);
    checkOutput("late_ack_rvalid", {62'd0, fInstrRvalid, fDataRvalid}, 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("late_ack_no_resp", {62'd0, fInstrRvalid, fDataRvalid}, 64'd0);
    checkOutput("late_ack_rdata", {32'd0, fInstrRdata}, 64'd0);
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("post_rst_gnt", {63'd0, fInstrGnt}, 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0BADF00D);
    checkOutput("post_rst_addr", {32'd0, fWbAddr}, 64'h400);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("post_rst_rvalid", {63'd0, fInstrRvalid}, 64'd1);
    checkOutput("post_rst_rdata", {32'd0, fInstrRdata}, 64'h0BADF00D);

`ifdef CORE_BUS_ARBITER_TIMEOUT_EN
    // Data read that is never acknowledged
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h700, 32'h0, 1'b0, 32'h0);
    checkOutput("to_gnt", {63'd0, fDataGnt}, 64'd1);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      checkOutput($sformatf("to_cyc%0d", k), {63'd0, fWbCyc}, 64'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("to_cyc_drop", {63'd0, fWbCyc}, 64'd0);
    checkOutput("to_rvalid", {63'd0, fDataRvalid}, 64'd1);
    checkOutput("to_err", {63'd0, fDataErr}, 64'd1);
    checkOutput("to_rdata", {32'd0, fDataRdata}, 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("to_err_pulse", {62'd0, fDataErr, fDataRvalid}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
